// File: rtl/activation_unit.sv
// Activation unit: streams accumulator rows, applies ReLU/none with an arithmetic
// shift, saturates each lane to a byte and writes the row out. Option: ACTIVATION_ROUND_EN.
module activation_unit #(
  parameter int MATRIX_WIDTH   = 14,
  parameter int ACC_WIDTH      = 32,
  parameter int ACC_ADDR_WIDTH = 16,
  parameter int BUF_ADDR_WIDTH = 24,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              enable_i,
  input  logic                              instr_valid_i,
  output logic                              instr_ready_o,
  input  logic [ACC_ADDR_WIDTH-1:0]         instr_acc_addr_i,
  input  logic [BUF_ADDR_WIDTH-1:0]         instr_buf_addr_i,
  input  logic [LEN_WIDTH-1:0]              instr_length_i,
  input  logic [1:0]                        instr_func_i,
  input  logic [4:0]                        instr_shift_i,
  output logic [ACC_ADDR_WIDTH-1:0]         acc_read_addr_o,
  input  logic [MATRIX_WIDTH*ACC_WIDTH-1:0] acc_data_i,
  output logic                              buf_write_en_o,
  output logic [BUF_ADDR_WIDTH-1:0]         buf_write_addr_o,
  output logic [MATRIX_WIDTH*8-1:0]         buf_data_o,
  output logic                              busy_o,
  output logic                              done_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic signed [ACC_WIDTH:0] SAT_U_MAX = (ACC_WIDTH+1)'(255);
  localparam logic signed [ACC_WIDTH:0] SAT_S_MAX = (ACC_WIDTH+1)'(127);
  localparam logic signed [ACC_WIDTH:0] SAT_S_MIN = (ACC_WIDTH+1)'(-128);

  // Shift (optionally rounded) and saturate one lane; the extra bit absorbs the rounding add.
  function automatic logic [7:0] quantize(input logic signed [ACC_WIDTH-1:0] acc,
                                          input logic [4:0] sh, input logic relu);
    logic signed [ACC_WIDTH:0] x;
    logic [7:0] q;
    x = {acc[ACC_WIDTH-1], acc};
`ifdef ACTIVATION_ROUND_EN
    if (sh != 5'd0) begin
      x = x + ({{ACC_WIDTH{1'b0}}, 1'b1} << (sh - 5'd1));
    end else begin
      x = x;
    end
`endif
    x = x >>> sh;
    if (relu) begin
      if (x[ACC_WIDTH]) q = 8'h00;
      else if (x > SAT_U_MAX) q = 8'hFF;
      else q = x[7:0];
    end else begin
      if (x < SAT_S_MIN) q = 8'h80;
      else if (x > SAT_S_MAX) q = 8'h7F;
      else q = x[7:0];
    end
    return q;
  endfunction

  state_t                            state_q, state_d;
  logic [ACC_ADDR_WIDTH-1:0]         rd_addr_q, rd_addr_d;
  logic [BUF_ADDR_WIDTH-1:0]         wr_addr_q, wr_addr_d;
  logic [LEN_WIDTH-1:0]              remain_q, remain_d;
  logic                              relu_q, relu_d;
  logic [4:0]                        shift_q, shift_d;
  logic                              valid_a_q, valid_a_d;
  logic [MATRIX_WIDTH*ACC_WIDTH-1:0] data_a_q, data_a_d;
  logic [BUF_ADDR_WIDTH-1:0]         addr_a_q, addr_a_d;
  logic                              valid_b_q, valid_b_d;
  logic [MATRIX_WIDTH*8-1:0]         data_b_q, data_b_d;
  logic [BUF_ADDR_WIDTH-1:0]         addr_b_q, addr_b_d;

  // Next-state logic: FSM, run counters, stage A capture and stage B quantization.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    remain_d  = remain_q;
    relu_d    = relu_q;
    shift_d   = shift_q;
    valid_a_d = 1'b0;
    data_a_d  = data_a_q;
    addr_a_d  = addr_a_q;
    valid_b_d = valid_a_q;
    data_b_d  = data_b_q;
    addr_b_d  = addr_b_q;
    case (state_q)
      IDLE: begin
        if (instr_valid_i) begin
          rd_addr_d = instr_acc_addr_i;
          wr_addr_d = instr_buf_addr_i;
          remain_d  = instr_length_i;
          relu_d    = (instr_func_i == 2'b01);
          shift_d   = instr_shift_i;
          state_d   = (instr_length_i == {LEN_WIDTH{1'b0}}) ? DRAIN : READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        valid_a_d = 1'b1;
        data_a_d  = acc_data_i;
        addr_a_d  = wr_addr_q;
        rd_addr_d = rd_addr_q + ACC_ADDR_WIDTH'(1);
        wr_addr_d = wr_addr_q + BUF_ADDR_WIDTH'(1);
        remain_d  = remain_q - LEN_WIDTH'(1);
        state_d   = (remain_q == LEN_WIDTH'(1)) ? DRAIN : READ;
      end
      DRAIN: begin
        // The last row sits in stage B during the done cycle and leaves on the exit edge.
        state_d = valid_a_q ? DRAIN : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (valid_a_q) begin
      addr_b_d = addr_a_q;
      for (int j = 0; j < MATRIX_WIDTH; j++) begin
        data_b_d[j*8 +: 8] = quantize(data_a_q[j*ACC_WIDTH +: ACC_WIDTH], shift_q, relu_q);
      end
    end else begin
      addr_b_d = addr_b_q;
    end
  end

  // State and pipeline registers; enable low freezes everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rd_addr_q <= {ACC_ADDR_WIDTH{1'b0}};
      wr_addr_q <= {BUF_ADDR_WIDTH{1'b0}};
      remain_q  <= {LEN_WIDTH{1'b0}};
      relu_q    <= 1'b0;
      shift_q   <= 5'd0;
      valid_a_q <= 1'b0;
      data_a_q  <= {(MATRIX_WIDTH*ACC_WIDTH){1'b0}};
      addr_a_q  <= {BUF_ADDR_WIDTH{1'b0}};
      valid_b_q <= 1'b0;
      data_b_q  <= {(MATRIX_WIDTH*8){1'b0}};
      addr_b_q  <= {BUF_ADDR_WIDTH{1'b0}};
    end else if (enable_i) begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      remain_q  <= remain_d;
      relu_q    <= relu_d;
      shift_q   <= shift_d;
      valid_a_q <= valid_a_d;
      data_a_q  <= data_a_d;
      addr_a_q  <= addr_a_d;
      valid_b_q <= valid_b_d;
      data_b_q  <= data_b_d;
      addr_b_q  <= addr_b_d;
    end
  end

  assign instr_ready_o    = (state_q == IDLE) && !rst_i;
  assign acc_read_addr_o  = rd_addr_q;
  assign buf_write_en_o   = valid_b_q && enable_i;
  assign buf_write_addr_o = addr_b_q;
  assign buf_data_o       = data_b_q;
  assign busy_o           = (state_q != IDLE);
  assign done_o           = (state_q == DRAIN) && !valid_a_q && enable_i;

endmodule

// File: tb/tb_activation_unit.sv
// Directed self-checking bench for activation_unit; expectations are hand-derived.
module tb_activation_unit;
  localparam int MW = 14;
  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, enable, instr_valid, instr_ready;
  logic [15:0]   instr_acc_addr;
  logic [23:0]   instr_buf_addr;
  logic [15:0]   instr_length;
  logic [1:0]    instr_func;
  logic [4:0]    instr_shift;
  logic [15:0]   acc_read_addr;
  logic [MW*AW-1:0] acc_data;
  logic          buf_write_en;
  logic [23:0]   buf_write_addr;
  logic [MW*8-1:0] buf_data;
  logic          busy, done;

  logic signed [31:0] mem [0:15][0:MW-1];
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int stall_viol = 0;
  logic [23:0]     wa[$];
  logic [MW*8-1:0] wd[$];
  int              wc[$];
  int              dc[$];

  activation_unit dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
    .instr_acc_addr_i(instr_acc_addr), .instr_buf_addr_i(instr_buf_addr),
    .instr_length_i(instr_length), .instr_func_i(instr_func), .instr_shift_i(instr_shift),
    .acc_read_addr_o(acc_read_addr), .acc_data_i(acc_data),
    .buf_write_en_o(buf_write_en), .buf_write_addr_o(buf_write_addr), .buf_data_o(buf_data),
    .busy_o(busy), .done_o(done)
  );

  always_comb begin
    for (int j = 0; j < MW; j++) acc_data[j*AW +: AW] = mem[acc_read_addr[3:0]][j];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (buf_write_en) begin
      wa.push_back(buf_write_addr);
      wd.push_back(buf_data);
      wc.push_back(cyc);
    end
    if (done) dc.push_back(cyc);
    if (!enable && buf_write_en) stall_viol <= stall_viol + 1;
  end

  task automatic fill_ramp(input int r, input int base);
    for (int j = 0; j < MW; j++) mem[r][j] = base + j;
  endtask

  task automatic set_row(input int r, input int v0, input int v1, input int v2, input int v3);
    for (int j = 0; j < MW; j++) mem[r][j] = 32'sd0;
    mem[r][0] = v0; mem[r][1] = v1; mem[r][2] = v2; mem[r][3] = v3;
  endtask

  task automatic issue(input logic [15:0] a, input logic [23:0] b, input logic [15:0] len,
                       input logic [1:0] f, input logic [4:0] s, output int e0);
    bit got = 1'b0;
    instr_acc_addr = a; instr_buf_addr = b; instr_length = len;
    instr_func = f; instr_shift = s; instr_valid = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (instr_ready && enable) got = 1'b1;
      @(posedge clk);
    end
    #1;
    instr_valid = 1'b0;
    e0 = cyc;
    n_total++;
    if (got !== 1'b1) $display("FAIL accept_timeout: ready never seen, got %0d expected 1", got);
    else n_pass++;
  endtask

  task automatic run_one(input logic [15:0] a, input logic [1:0] f, input logic [4:0] s,
                         output logic [MW*8-1:0] d, output int nw);
    int e0, w0;
    w0 = wa.size();
    issue(a, 24'h000100, 16'd1, f, s, e0);
    repeat (6) @(posedge clk);
    #1;
    nw = wa.size() - w0;
    d = (nw > 0) ? wd[w0] : {(MW*8){1'b0}};
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; instr_valid = 1'b0;
    instr_acc_addr = 16'h0; instr_buf_addr = 24'h0; instr_length = 16'h0;
    instr_func = 2'b00; instr_shift = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (instr_ready !== 1'b0) $display("FAIL rst_ready: got %b expected 0", instr_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (buf_write_en !== 1'b0) $display("FAIL rst_wen: got %b expected 0", buf_write_en); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else n_pass++;
    n_total++; if (acc_read_addr !== 16'h0) $display("FAIL rst_raddr: got %h expected 0", acc_read_addr); else n_pass++;
    n_total++; if (buf_write_addr !== 24'h0) $display("FAIL rst_waddr: got %h expected 0", buf_write_addr); else n_pass++;
    n_total++; if (buf_data !== {(MW*8){1'b0}}) $display("FAIL rst_data: got %h expected 0", buf_data); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (instr_ready !== 1'b1) $display("FAIL rst_ready_after: got %b expected 1", instr_ready); else n_pass++;
  endtask

  task automatic test_passthrough();
    int e0, w0, d0;
    logic [MW*8-1:0] exp;
    for (int i = 0; i < 4; i++) fill_ramp(i, i);
    w0 = wa.size(); d0 = dc.size();
    issue(16'h0000, 24'h000010, 16'd4, 2'b00, 5'd0, e0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_total++; if (done !== 1'b1) $display("FAIL pt_done_cycle: got %b expected 1", done); else n_pass++;
    n_total++; if (instr_ready !== 1'b0) $display("FAIL pt_ready_at_done: got %b expected 0", instr_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (instr_ready !== 1'b1) $display("FAIL pt_ready_after: got %b expected 1", instr_ready); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL pt_done_single: got %b expected 0", done); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (wa.size() - w0 !== 4) $display("FAIL pt_nwrites: got %0d expected 4", wa.size() - w0); else n_pass++;
    for (int i = 0; i < 4 && w0 + i < wa.size(); i++) begin
      for (int j = 0; j < MW; j++) exp[j*8 +: 8] = 8'(i + j);
      n_total++; if (wa[w0+i] !== 24'(16 + i)) $display("FAIL pt_addr%0d: got %h expected %h", i, wa[w0+i], 24'(16 + i)); else n_pass++;
      n_total++; if (wd[w0+i] !== exp) $display("FAIL pt_data%0d: got %h expected %h", i, wd[w0+i], exp); else n_pass++;
      n_total++; if (wc[w0+i] !== e0 + 2 + i) $display("FAIL pt_cycle%0d: got %0d expected %0d", i, wc[w0+i] - e0, 2 + i); else n_pass++;
    end
    n_total++; if (dc.size() - d0 !== 1) $display("FAIL pt_ndone: got %0d expected 1", dc.size() - d0); else n_pass++;
    if (dc.size() > d0) begin
      n_total++; if (dc[d0] !== e0 + 5) $display("FAIL pt_done_at: got %0d expected %0d", dc[d0] - e0, 5); else n_pass++;
    end
  endtask

  task automatic test_relu_sat();
    logic [MW*8-1:0] d, exp;
    int nw;
    set_row(4, -5, 300, 127, -200000);
    run_one(16'h0004, 2'b01, 5'd0, d, nw);
    exp = {(MW*8){1'b0}}; exp[31:0] = {8'h00, 8'h7F, 8'hFF, 8'h00};
    n_total++; if (nw !== 1) $display("FAIL relu_nwrites: got %0d expected 1", nw); else n_pass++;
    n_total++; if (d !== exp) $display("FAIL relu_data: got %h expected %h", d, exp); else n_pass++;
    run_one(16'h0004, 2'b00, 5'd0, d, nw);
    exp[31:0] = {8'h80, 8'h7F, 8'h7F, 8'hFB};
    n_total++; if (d !== exp) $display("FAIL none_sat_data: got %h expected %h", d, exp); else n_pass++;
    run_one(16'h0004, 2'b10, 5'd0, d, nw);
    n_total++; if (d !== exp) $display("FAIL reserved_func: got %h expected %h", d, exp); else n_pass++;
  endtask

  task automatic test_shift();
    logic [MW*8-1:0] d, exp;
    int nw;
    set_row(5, 1000, -7, 1003, 1004);
    run_one(16'h0005, 2'b00, 5'd3, d, nw);
    exp = {(MW*8){1'b0}};
`ifdef ACTIVATION_ROUND_EN
    exp[31:0] = {8'h7E, 8'h7D, 8'hFF, 8'h7D};
`else
    exp[31:0] = {8'h7D, 8'h7D, 8'hFF, 8'h7D};
`endif
    n_total++; if (d !== exp) $display("FAIL shift_data: got %h expected %h", d, exp); else n_pass++;
  endtask

  task automatic test_stall();
    int e0, w0, d0, v0;
    logic [MW*8-1:0] exp;
    for (int i = 0; i < 6; i++) fill_ramp(8 + i, 10 * i);
    w0 = wa.size(); d0 = dc.size(); v0 = stall_viol;
    issue(16'h0008, 24'h000200, 16'd6, 2'b00, 5'd0, e0);
    repeat (2) @(posedge clk);
    #1 enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 enable = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_total++; if (stall_viol !== v0) $display("FAIL stall_wen_low: got %0d expected 0", stall_viol - v0); else n_pass++;
    n_total++; if (wa.size() - w0 !== 6) $display("FAIL stall_nwrites: got %0d expected 6", wa.size() - w0); else n_pass++;
    for (int i = 0; i < 6 && w0 + i < wa.size(); i++) begin
      for (int j = 0; j < MW; j++) exp[j*8 +: 8] = 8'(10 * i + j);
      n_total++; if (wa[w0+i] !== 24'(512 + i)) $display("FAIL stall_addr%0d: got %h expected %h", i, wa[w0+i], 24'(512 + i)); else n_pass++;
      n_total++; if (wd[w0+i] !== exp) $display("FAIL stall_data%0d: got %h expected %h", i, wd[w0+i], exp); else n_pass++;
    end
    n_total++; if (dc.size() - d0 !== 1) $display("FAIL stall_ndone: got %0d expected 1", dc.size() - d0); else n_pass++;
    if (dc.size() > d0) begin
      n_total++; if (dc[d0] !== e0 + 10) $display("FAIL stall_done_at: got %0d expected 10", dc[d0] - e0); else n_pass++;
    end
  endtask

  task automatic test_wrap_zero();
    int e0, w0, d0;
    logic [MW*8-1:0] exp;
    fill_ramp(15, 32); fill_ramp(0, 64);
    w0 = wa.size();
    issue(16'hFFFF, 24'hFFFFFF, 16'd2, 2'b00, 5'd0, e0);
    n_total++; if (acc_read_addr !== 16'hFFFF) $display("FAIL wrap_raddr0: got %h expected ffff", acc_read_addr); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (acc_read_addr !== 16'h0000) $display("FAIL wrap_raddr1: got %h expected 0000", acc_read_addr); else n_pass++;
    repeat (6) @(posedge clk); #1;
    n_total++; if (wa.size() - w0 !== 2) $display("FAIL wrap_nwrites: got %0d expected 2", wa.size() - w0); else n_pass++;
    for (int i = 0; i < 2 && w0 + i < wa.size(); i++) begin
      for (int j = 0; j < MW; j++) exp[j*8 +: 8] = 8'(32 + 32 * i + j);
      n_total++; if (wa[w0+i] !== 24'(24'hFFFFFF + 24'(i))) $display("FAIL wrap_waddr%0d: got %h", i, wa[w0+i]); else n_pass++;
      n_total++; if (wd[w0+i] !== exp) $display("FAIL wrap_data%0d: got %h expected %h", i, wd[w0+i], exp); else n_pass++;
    end
    w0 = wa.size(); d0 = dc.size();
    issue(16'h0003, 24'h000050, 16'd0, 2'b00, 5'd0, e0);
    @(negedge clk);
    n_total++; if (done !== 1'b1) $display("FAIL zero_done: got %b expected 1", done); else n_pass++;
    repeat (4) @(posedge clk); #1;
    n_total++; if (wa.size() - w0 !== 0) $display("FAIL zero_nwrites: got %0d expected 0", wa.size() - w0); else n_pass++;
    n_total++; if (dc.size() - d0 !== 1) $display("FAIL zero_ndone: got %0d expected 1", dc.size() - d0); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    int e0, w0, d0;
    for (int i = 0; i < 4; i++) fill_ramp(i, i);
    issue(16'h0000, 24'h000030, 16'd4, 2'b00, 5'd0, e0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    n_total++; if (busy !== 1'b0) $display("FAIL mrst_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (buf_write_en !== 1'b0) $display("FAIL mrst_wen: got %b expected 0", buf_write_en); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL mrst_done: got %b expected 0", done); else n_pass++;
    n_total++; if (instr_ready !== 1'b0) $display("FAIL mrst_ready: got %b expected 0", instr_ready); else n_pass++;
    n_total++; if (acc_read_addr !== 16'h0) $display("FAIL mrst_raddr: got %h expected 0", acc_read_addr); else n_pass++;
    n_total++; if (buf_data !== {(MW*8){1'b0}}) $display("FAIL mrst_data: got %h expected 0", buf_data); else n_pass++;
    rst = 1'b0;
    w0 = wa.size(); d0 = dc.size();
    #1;
    n_total++; if (instr_ready !== 1'b1) $display("FAIL mrst_ready_after: got %b expected 1", instr_ready); else n_pass++;
    repeat (8) @(posedge clk); #1;
    n_total++; if (wa.size() + dc.size() - w0 - d0 !== 0) $display("FAIL mrst_quiet: got %0d events expected 0", wa.size() + dc.size() - w0 - d0); else n_pass++;
    issue(16'h0001, 24'h000040, 16'd2, 2'b00, 5'd0, e0);
    repeat (6) @(posedge clk); #1;
    n_total++; if (wa.size() - w0 !== 2) $display("FAIL mrst_rerun_writes: got %0d expected 2", wa.size() - w0); else n_pass++;
    n_total++; if (dc.size() - d0 !== 1) $display("FAIL mrst_rerun_done: got %0d expected 1", dc.size() - d0); else n_pass++;
    if (wa.size() > w0 + 1) begin
      n_total++; if (wa[w0+1] !== 24'h000041) $display("FAIL mrst_rerun_addr: got %h expected 000041", wa[w0+1]); else n_pass++;
    end
  endtask

  initial begin
    for (int r = 0; r < 16; r++) fill_ramp(r, 0);
    test_reset();
    test_passthrough();
    test_relu_sat();
    test_shift();
    test_stall();
    test_wrap_zero();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
